inst_bus_ctrl: RTL and testbench



---
 rtl/inst_bus_ctrl_pkg.sv | 28 ++
 rtl/inst_bus_ctrl_decode.sv | 29 ++
 rtl/inst_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_inst_bus_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_bus_ctrl_pkg.sv
// Shared definitions for the instruction-bus controller and its address decoder:
// FSM state encodings, region codes and the default region prefixes.
package inst_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_ACC = 2'd1,
        ROM_ACC = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_RAM  = 2'd1,
        REG_ROM  = 2'd2
    } region_e;

    localparam int         DEF_RAM_PREFIX_W  = 8;
    localparam logic [7:0] DEF_RAM_PREFIX    = 8'h00;
    localparam int         DEF_BOOT_PREFIX_W = 12;
    localparam logic [11:0] DEF_BOOT_PREFIX  = 12'h1fc;

    // Larger of two elaboration-time integers (used for derived widths).
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/inst_bus_ctrl_decode.sv
// inst_bus_decode: combinational address-to-region decoder. Takes only the
// upper address bits that the region prefixes look at. RAM wins over ROM when
// both prefixes would match; anything else is unmapped. Shared with the data bus.
module inst_bus_decode
    import inst_bus_ctrl_pkg::*;
#(
    parameter int                         HI_W          = 12,
    parameter int                         RAM_PREFIX_W  = DEF_RAM_PREFIX_W,
    parameter logic [RAM_PREFIX_W-1:0]    RAM_PREFIX    = DEF_RAM_PREFIX,
    parameter int                         BOOT_PREFIX_W = DEF_BOOT_PREFIX_W,
    parameter logic [BOOT_PREFIX_W-1:0]   BOOT_PREFIX   = DEF_BOOT_PREFIX
) (
    input  logic [HI_W-1:0] addr_hi,
    output region_e         region
);

    // Prefix compare with RAM taking priority over the boot ROM.
    always_comb begin
        region = REG_NONE;
        if (addr_hi[HI_W-1 -: RAM_PREFIX_W] == RAM_PREFIX) begin
            region = REG_RAM;
        end else if (addr_hi[HI_W-1 -: BOOT_PREFIX_W] == BOOT_PREFIX) begin
            region = REG_ROM;
        end else begin
            region = REG_NONE;
        end
    end

endmodule

// File: rtl/inst_bus_ctrl.sv
// inst_bus_ctrl: sequential instruction-bus controller. Accepts one access at a
// time over valid/ready, decodes it to SRAM / boot ROM / unmapped, runs a
// per-target wait FSM and returns a one-cycle registered response.
// Optional build macro INST_BUS_LAST_HIT_EN adds a single-entry last-read
// buffer that answers a repeated read in one cycle without touching the target.
module inst_bus_ctrl
    import inst_bus_ctrl_pkg::*;
#(
    parameter int                       ADDR_W        = 32,
    parameter int                       DATA_W        = 32,
    parameter int                       RAM_PREFIX_W  = DEF_RAM_PREFIX_W,
    parameter logic [RAM_PREFIX_W-1:0]  RAM_PREFIX    = DEF_RAM_PREFIX,
    parameter int                       BOOT_PREFIX_W = DEF_BOOT_PREFIX_W,
    parameter logic [BOOT_PREFIX_W-1:0] BOOT_PREFIX   = DEF_BOOT_PREFIX,
    parameter int                       RAM_ADDR_W    = 24,
    parameter int                       ROM_ADDR_W    = 13,
    parameter int                       RAM_WAIT      = 0,
    parameter int                       ROM_LATENCY   = 1,
    parameter int                       CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dev_req_valid,
    output logic                  dev_req_ready,
    input  logic                  dev_req_write,
    input  logic [ADDR_W-1:0]     dev_req_addr,
    input  logic [DATA_W-1:0]     dev_req_wdata,
    input  logic [DATA_W/8-1:0]   dev_req_be,
    output logic                  dev_resp_valid,
    output logic [DATA_W-1:0]     dev_resp_rdata,
    output logic                  dev_resp_err,
    output logic                  inst_bus_stall,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    output logic                  ram_read_enable,
    output logic                  ram_write_enable,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic                  ram_stall,
    output logic [ROM_ADDR_W-1:0] bootrom_addr,
    input  logic [DATA_W-1:0]     bootrom_data
);

    localparam int BE_W = DATA_W / 8;
    localparam int HI_W = max_int(RAM_PREFIX_W, BOOT_PREFIX_W);
`ifdef INST_BUS_LAST_HIT_EN
    // The buffer compares whole addresses, so the full address is kept.
    localparam int LAT_W = ADDR_W;
`else
    localparam int LAT_W = max_int(RAM_ADDR_W, ROM_ADDR_W);
`endif
    localparam logic [CNT_W-1:0] RAM_WAIT_C = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] ROM_LAT_C  = CNT_W'(ROM_LATENCY);

    state_e              state_r;
    state_e              state_nx_s;
    region_e             region_s;
    logic [LAT_W-1:0]    addr_r;
    logic                write_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [BE_W-1:0]     be_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nx_s;
    logic [CNT_W-1:0]    cnt_sat_s;
    logic [DATA_W-1:0]   rdata_r;
    logic                err_r;
    logic                ready_r;
    logic                resp_valid_r;
    logic                stall_r;
    logic                rd_en_r;
    logic                wr_en_r;
    logic                accept_s;
    logic                capture_s;
    logic                err_nx_s;
    logic                write_nx_s;
    logic [DATA_W-1:0]   cap_data_s;
    logic [DATA_W-1:0]   acc_rdata_s;
    logic                hit_s;
    logic [DATA_W-1:0]   hit_data_s;

    inst_bus_decode #(
        .HI_W          (HI_W),
        .RAM_PREFIX_W  (RAM_PREFIX_W),
        .RAM_PREFIX    (RAM_PREFIX),
        .BOOT_PREFIX_W (BOOT_PREFIX_W),
        .BOOT_PREFIX   (BOOT_PREFIX)
    ) u_decode (
        .addr_hi (dev_req_addr[ADDR_W-1 -: HI_W]),
        .region  (region_s)
    );

`ifdef INST_BUS_LAST_HIT_EN
    logic              lh_valid_r;
    logic [ADDR_W-1:0] lh_addr_r;
    logic [DATA_W-1:0] lh_data_r;

    assign hit_s      = dev_req_valid && !dev_req_write && lh_valid_r &&
                        (dev_req_addr == lh_addr_r);
    assign hit_data_s = lh_data_r;

    // Last-read buffer: cleared by reset and RAM writes, refilled by each completed read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lh_valid_r <= 1'b0;
            lh_addr_r  <= {ADDR_W{1'b0}};
            lh_data_r  <= {DATA_W{1'b0}};
        end else if (accept_s && dev_req_write && (region_s == REG_RAM)) begin
            lh_valid_r <= 1'b0;
        end else if (capture_s && !write_r) begin
            lh_valid_r <= 1'b1;
            lh_addr_r  <= addr_r;
            lh_data_r  <= cap_data_s;
        end else begin
            lh_valid_r <= lh_valid_r;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign hit_data_s = {DATA_W{1'b0}};
`endif

    assign cnt_sat_s  = (cnt_r == {CNT_W{1'b1}}) ? cnt_r
                                                 : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign write_nx_s = accept_s ? dev_req_write : write_r;

    // Next-state, counter and capture decisions for the access FSM.
    always_comb begin
        state_nx_s  = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        cap_data_s  = {DATA_W{1'b0}};
        acc_rdata_s = {DATA_W{1'b0}};
        cnt_nx_s    = cnt_r;
        err_nx_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (dev_req_valid) begin
                    accept_s = 1'b1;
                    cnt_nx_s = {CNT_W{1'b0}};
                    if (hit_s) begin
                        state_nx_s  = RESP;
                        acc_rdata_s = hit_data_s;
                    end else begin
                        case (region_s)
                            REG_RAM: state_nx_s = RAM_ACC;
                            REG_ROM: begin
                                if (dev_req_write) begin
                                    state_nx_s = RESP;
                                    err_nx_s   = 1'b1;
                                end else begin
                                    state_nx_s = ROM_ACC;
                                end
                            end
                            default: begin
                                state_nx_s = RESP;
                                err_nx_s   = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RAM_ACC: begin
                if ((cnt_r >= RAM_WAIT_C) && !ram_stall) begin
                    capture_s  = 1'b1;
                    cap_data_s = write_r ? {DATA_W{1'b0}} : ram_rdata;
                    state_nx_s = RESP;
                end else begin
                    cnt_nx_s = cnt_sat_s;
                end
            end
            ROM_ACC: begin
                if (cnt_r == ROM_LAT_C) begin
                    capture_s  = 1'b1;
                    cap_data_s = bootrom_data;
                    state_nx_s = RESP;
                end else begin
                    cnt_nx_s = cnt_sat_s;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, request latches, response data and registered output strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            addr_r       <= {LAT_W{1'b0}};
            write_r      <= 1'b0;
            wdata_r      <= {DATA_W{1'b0}};
            be_r         <= {BE_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
            err_r        <= 1'b0;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            stall_r      <= 1'b0;
            rd_en_r      <= 1'b0;
            wr_en_r      <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            ready_r      <= (state_nx_s == IDLE);
            resp_valid_r <= (state_nx_s == RESP);
            stall_r      <= (state_nx_s != IDLE);
            rd_en_r      <= (state_nx_s == RAM_ACC) && !write_nx_s;
            wr_en_r      <= (state_nx_s == RAM_ACC) && write_nx_s;
            if (accept_s) begin
                addr_r  <= dev_req_addr[LAT_W-1:0];
                write_r <= dev_req_write;
                wdata_r <= dev_req_wdata;
                be_r    <= dev_req_write ? dev_req_be : {BE_W{1'b1}};
                rdata_r <= acc_rdata_s;
                err_r   <= err_nx_s;
            end else if (capture_s) begin
                rdata_r <= cap_data_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign dev_req_ready    = ready_r;
    assign dev_resp_valid   = resp_valid_r;
    assign dev_resp_rdata   = rdata_r;
    assign dev_resp_err     = err_r;
    assign inst_bus_stall   = stall_r;
    assign ram_addr         = addr_r[RAM_ADDR_W-1:0];
    assign ram_wdata        = wdata_r;
    assign ram_be           = be_r;
    assign ram_read_enable  = rd_en_r;
    assign ram_write_enable = wr_en_r;
    assign bootrom_addr     = addr_r[ROM_ADDR_W-1:0];

endmodule

// File: tb/tb_inst_bus_ctrl.sv
// Self-checking bench for inst_bus_ctrl. A transaction-level model derives,
// for each access, its latency, strobe window and response from the region
// rules; a per-cycle compare process checks the DUT against that schedule,
// and each access also checks its latency and response against literals.
module tb_inst_bus_ctrl;

    localparam int RAM_WAIT = 0;
    localparam int ROM_LAT  = 1;
    localparam int MAXC     = 1000;
`ifdef INST_BUS_LAST_HIT_EN
    localparam bit LH_EN = 1'b1;
`else
    localparam bit LH_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        dev_req_valid;
    logic        dev_req_ready;
    logic        dev_req_write;
    logic [31:0] dev_req_addr;
    logic [31:0] dev_req_wdata;
    logic [3:0]  dev_req_be;
    logic        dev_resp_valid;
    logic [31:0] dev_resp_rdata;
    logic        dev_resp_err;
    logic        inst_bus_stall;
    logic [23:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_read_enable;
    logic        ram_write_enable;
    logic [31:0] ram_rdata;
    logic        ram_stall;
    logic [12:0] bootrom_addr;
    logic [31:0] bootrom_data;

    inst_bus_ctrl #(
        .RAM_WAIT    (RAM_WAIT),
        .ROM_LATENCY (ROM_LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dev_req_valid    (dev_req_valid),
        .dev_req_ready    (dev_req_ready),
        .dev_req_write    (dev_req_write),
        .dev_req_addr     (dev_req_addr),
        .dev_req_wdata    (dev_req_wdata),
        .dev_req_be       (dev_req_be),
        .dev_resp_valid   (dev_resp_valid),
        .dev_resp_rdata   (dev_resp_rdata),
        .dev_resp_err     (dev_resp_err),
        .inst_bus_stall   (inst_bus_stall),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_be           (ram_be),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .ram_rdata        (ram_rdata),
        .ram_stall        (ram_stall),
        .bootrom_addr     (bootrom_addr),
        .bootrom_data     (bootrom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Expected per-cycle behaviour (index = cycle number)
    bit          e_ready [MAXC];
    bit          e_valid [MAXC];
    bit          e_rd    [MAXC];
    bit          e_wr    [MAXC];
    bit          e_rom   [MAXC];
    bit          e_err   [MAXC];
    logic [31:0] e_rdata [MAXC];
    logic [31:0] e_wdata [MAXC];
    logic [3:0]  e_be    [MAXC];
    logic [23:0] e_raddr [MAXC];
    logic [12:0] e_romad [MAXC];

    // Model of the last-read buffer
    bit          lh_v = 1'b0;
    logic [31:0] lh_a = 32'h0;
    logic [31:0] lh_d = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            e_ready[i] = 1'b1; e_valid[i] = 1'b0; e_rd[i] = 1'b0; e_wr[i] = 1'b0;
            e_rom[i] = 1'b0; e_err[i] = 1'b0; e_rdata[i] = 32'h0; e_wdata[i] = 32'h0;
            e_be[i] = 4'h0; e_raddr[i] = 24'h0; e_romad[i] = 13'h0;
        end
    endtask

    // 1 = RAM (checked first), 2 = boot ROM, 0 = unmapped
    function automatic int region_of(input logic [31:0] a);
        if (a[31:24] == 8'h00) return 1;
        if (a[31:20] == 12'h1fc) return 2;
        return 0;
    endfunction

    // Schedule expectations for an access accepted at the end of cycle c.
    task automatic plan(input int c, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int s, input logic [31:0] src);
        int          reg_c;
        int          lat;
        bit          err;
        logic [31:0] rd;
        reg_c = region_of(addr);
        err   = 1'b0;
        rd    = 32'h0;
        if (LH_EN && !wr && lh_v && (addr == lh_a)) begin
            lat = 1; rd = lh_d;
        end else if (reg_c == 0 || (reg_c == 2 && wr)) begin
            lat = 1; err = 1'b1;
        end else if (reg_c == 1) begin
            lat = 2 + RAM_WAIT + s;
            rd  = wr ? 32'h0 : src;
            for (int i = c + 1; i < c + lat; i++) begin
                e_rd[i] = !wr; e_wr[i] = wr; e_raddr[i] = addr[23:0];
                e_be[i] = wr ? be : 4'hF; e_wdata[i] = wdata;
            end
            if (wr) lh_v = 1'b0;
            else begin lh_v = 1'b1; lh_a = addr; lh_d = rd; end
        end else begin
            lat = 2 + ROM_LAT;
            rd  = src;
            for (int i = c + 1; i < c + lat; i++) begin
                e_rom[i] = 1'b1; e_romad[i] = addr[12:0];
            end
            lh_v = 1'b1; lh_a = addr; lh_d = rd;
        end
        for (int i = c + 1; i <= c + lat; i++) e_ready[i] = 1'b0;
        e_valid[c + lat] = 1'b1;
        e_rdata[c + lat] = rd;
        e_err[c + lat]   = err;
    endtask

    // Per-cycle compare against the model schedule
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("ready", dev_req_ready, e_ready[cyc]);
            chk("stall", inst_bus_stall, !e_ready[cyc]);
            chk("resp_valid", dev_resp_valid, e_valid[cyc]);
            chk("ram_rd_en", ram_read_enable, e_rd[cyc]);
            chk("ram_wr_en", ram_write_enable, e_wr[cyc]);
            if (e_rd[cyc] || e_wr[cyc]) begin
                chk("ram_addr", ram_addr, e_raddr[cyc]);
                chk("ram_be", ram_be, e_be[cyc]);
            end
            if (e_wr[cyc]) chk("ram_wdata", ram_wdata, e_wdata[cyc]);
            if (e_rom[cyc]) chk("bootrom_addr", bootrom_addr, e_romad[cyc]);
            if (e_valid[cyc]) begin
                chk("resp_rdata", dev_resp_rdata, e_rdata[cyc]);
                chk("resp_err", dev_resp_err, e_err[cyc]);
            end
        end
    end

    // One access from an idle cycle; x_* are hand-computed literals.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int s, input logic [31:0] src,
                          input int x_lat, input logic [31:0] x_rdata, input bit x_err);
        int c;
        bit got;
        int lat;
        c = cyc;
        plan(c, wr, addr, wdata, be, s, src);
        ram_rdata     = src;
        bootrom_data  = src;
        dev_req_valid = 1'b1;
        dev_req_write = wr;
        dev_req_addr  = addr;
        dev_req_wdata = wdata;
        dev_req_be    = be;
        @(posedge clk); #1;
        // Garbage while busy must be ignored
        dev_req_valid = 1'b1;
        dev_req_write = 1'b1;
        dev_req_addr  = 32'h0000_0040;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            ram_stall = (k <= s);
            if (dev_resp_valid) begin
                got = 1'b1;
                lat = k;
                chk("lit_rdata", dev_resp_rdata, x_rdata);
                chk("lit_err", dev_resp_err, x_err);
            end else begin
                @(posedge clk); #1;
            end
        end
        dev_req_valid = 1'b0;
        ram_stall     = 1'b0;
        if (!got) chk("resp_timeout", 32'(got), 32'd1);
        else chk("lit_latency", lat, x_lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int c;
        clear_from(0);
        rst_n = 1'b0;
        dev_req_valid = 1'b0; dev_req_write = 1'b0; dev_req_addr = 32'h0;
        dev_req_wdata = 32'h0; dev_req_be = 4'h0;
        ram_rdata = 32'h0; ram_stall = 1'b0; bootrom_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Reset state
        chk("rst_ready", dev_req_ready, 32'd1);
        chk("rst_valid", dev_resp_valid, 32'd0);
        chk("rst_rdata", dev_resp_rdata, 32'd0);
        chk("rst_err", dev_resp_err, 32'd0);
        chk("rst_stall", inst_bus_stall, 32'd0);
        chk("rst_rd", ram_read_enable, 32'd0);
        chk("rst_wr", ram_write_enable, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_be", ram_be, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_rom_addr", bootrom_addr, 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 32'h1FC0_0004, 32'h0, 4'h0, 0, 32'h3C1A_0000, 3, 32'h3C1A_0000, 1'b0);
        access(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0011, 3, 32'h1234_5678, 5, 32'h0, 1'b0);
        access(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h1234_5678, 1, 32'h0, 1'b1);
        access(1'b1, 32'h1FC0_0000, 32'hFFFF_FFFF, 4'hF, 0, 32'h1234_5678, 1, 32'h0, 1'b1);
        access(1'b0, 32'h00AB_CDEC, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 4, 32'h0BAD_F00D, 1'b0);
        access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0);
`ifdef INST_BUS_LAST_HIT_EN
        access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h1111_1111, 1, 32'hDEAD_BEEF, 1'b0);
`else
        access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h1111_1111, 2, 32'h1111_1111, 1'b0);
`endif
        access(1'b1, 32'h0000_0020, 32'h0F0F_0F0F, 4'hF, 0, 32'h0, 2, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h2222_2222, 2, 32'h2222_2222, 1'b0);

        // Reset in the middle of a stalled RAM read
        c = cyc;
        plan(c, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 6, 32'h5A5A_5A5A);
        ram_rdata = 32'h5A5A_5A5A;
        dev_req_valid = 1'b1; dev_req_write = 1'b0; dev_req_addr = 32'h0000_0200;
        @(posedge clk); #1;
        dev_req_valid = 1'b0;
        ram_stall = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ram_stall = 1'b0;
        clear_from(c + 3);
        lh_v = 1'b0;
        chk("midrst_ready", dev_req_ready, 32'd1);
        chk("midrst_rd", ram_read_enable, 32'd0);
        chk("midrst_valid", dev_resp_valid, 32'd0);
        chk("midrst_stall", inst_bus_stall, 32'd0);
        chk("midrst_rdata", dev_resp_rdata, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h3333_3333, 2, 32'h3333_3333, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
